// File: rtl/mips_io_pkg.sv
//============================================================================
// mips_io_pkg - shared address map, status bit layout and decode helper. Rev 1.0
//============================================================================
`default_nettype none

package mips_io_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] PORTOUT_ADDR_DEF = 32'h1001_0024;
  localparam logic [DATA_W-1:0] PORTIN_ADDR_DEF  = 32'h1001_0028;
  localparam logic [DATA_W-1:0] STATUS_ADDR_DEF  = 32'h1001_002C;

  localparam int CHANGED_BIT = 0;
  localparam int OVERRUN_BIT = 1;

  typedef enum logic [1:0] {
    SEL_NONE    = 2'd0,
    SEL_PORTOUT = 2'd1,
    SEL_PORTIN  = 2'd2,
    SEL_STATUS  = 2'd3
  } io_sel_e;

  function automatic io_sel_e decode_addr(
    input logic [DATA_W-1:0] addr,
    input logic [DATA_W-1:0] portout_addr,
    input logic [DATA_W-1:0] portin_addr,
    input logic [DATA_W-1:0] status_addr
  );
    io_sel_e sel;
    sel = SEL_NONE;
    if (addr == portout_addr)     sel = SEL_PORTOUT;
    else if (addr == portin_addr) sel = SEL_PORTIN;
    else if (addr == status_addr) sel = SEL_STATUS;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_debouncer.sv
//============================================================================
// input_debouncer - two-flop synchronizer plus hold-time debounce filter. Rev 1.0
//============================================================================
`default_nettype none

module input_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             update_o
);

  localparam int             CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             update_d;

  // A value moving from sync1 into sync2 at this edge restarts qualification,
  // so the count covers DEBOUNCE_CYCLES edges with sync2 held constant.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    update_d = 1'b0;
    if ((sync1_q != sync2_q) || (sync2_q == stable_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      stable_d = sync2_q;
      update_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= data_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign update_o = update_d;

endmodule

`default_nettype wire

// File: rtl/io_port_controller.sv
//============================================================================
// io_port_controller - memory-mapped output port, debounced input port and
// sticky change/overrun status. Rev 1.0
//============================================================================
`default_nettype none

module io_port_controller
  import mips_io_pkg::*;
#(
  parameter logic [31:0] PORTOUT_ADDR    = PORTOUT_ADDR_DEF,
  parameter logic [31:0] PORTIN_ADDR     = PORTIN_ADDR_DEF,
  parameter logic [31:0] STATUS_ADDR     = STATUS_ADDR_DEF,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [7:0]        PortIn,
  output logic [DATA_W-1:0] ReadData,
  output logic              IOSelect,
  output logic [DATA_W-1:0] PortOut
);

  io_sel_e           sel;
  logic [7:0]        stable;
  logic              update;
  logic              status_rd;
  logic [DATA_W-1:0] portout_q, portout_d;
  logic              changed_q, changed_d;
  logic              overrun_q, overrun_d;

  input_debouncer #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .data_i  (PortIn),
    .stable_o(stable),
    .update_o(update)
  );

  assign sel       = decode_addr(Address, PORTOUT_ADDR, PORTIN_ADDR, STATUS_ADDR);
  assign IOSelect  = (sel != SEL_NONE);
  assign status_rd = MemRead && (sel == SEL_STATUS);

  always_comb begin
    ReadData = '0;
    case (sel)
      SEL_PORTOUT: ReadData = portout_q;
      SEL_PORTIN:  ReadData = {24'b0, stable};
      SEL_STATUS: begin
        ReadData[CHANGED_BIT] = changed_q;
        ReadData[OVERRUN_BIT] = overrun_q;
      end
      default:     ReadData = '0;
    endcase
  end

  // A Stable update landing on the same edge as a status read takes priority.
  always_comb begin
    portout_d = portout_q;
    changed_d = changed_q;
    overrun_d = overrun_q;
    if (MemWrite && (sel == SEL_PORTOUT)) portout_d = WriteData;
    if (update) begin
      changed_d = 1'b1;
      overrun_d = status_rd ? 1'b0 : (overrun_q | changed_q);
    end else if (status_rd) begin
      changed_d = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      portout_q <= '0;
      changed_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      portout_q <= portout_d;
      changed_q <= changed_d;
      overrun_q <= overrun_d;
    end
  end

  assign PortOut = portout_q;

endmodule

`default_nettype wire

// File: tb/tb_io_port_controller.sv
//============================================================================
// tb_io_port_controller - scoreboard bench with a sample-window reference model. Rev 1.0
//============================================================================
`default_nettype none

module tb_io_port_controller;

  localparam int          D    = 4;
  localparam logic [31:0] A_PO = 32'h1001_0024;
  localparam logic [31:0] A_PI = 32'h1001_0028;
  localparam logic [31:0] A_ST = 32'h1001_002C;
  localparam logic [31:0] A_UN = 32'h1001_0030;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [7:0]  PortIn = '0;
  logic [31:0] ReadData;
  logic        IOSelect;
  logic [31:0] PortOut;

  always #5 clk = ~clk;

  io_port_controller #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .PortIn   (PortIn),
    .ReadData (ReadData),
    .IOSelect (IOSelect),
    .PortOut  (PortOut)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd;
    logic        sel;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the last D+1 pin samples seen at clock edges. Stable takes
  // a value once every sample in that window agrees and differs from Stable.
  logic [7:0]  hist [0:D];
  logic [7:0]  m_stable;
  logic        m_chg, m_ovr;
  logic [31:0] m_portout;

  function automatic bit window_qualifies();
    bit ok;
    ok = (hist[0] != m_stable);
    for (int i = 1; i <= D; i++) if (hist[i] != hist[0]) ok = 1'b0;
    return ok;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= D; i++) hist[i] <= '0;
      m_stable  <= '0;
      m_chg     <= 1'b0;
      m_ovr     <= 1'b0;
      m_portout <= '0;
    end else begin
      hist[0] <= PortIn;
      for (int i = 1; i <= D; i++) hist[i] <= hist[i-1];
      if (MemWrite && Address == A_PO) m_portout <= WriteData;
      if (window_qualifies()) begin
        m_stable <= hist[0];
        m_chg    <= 1'b1;
        m_ovr    <= (MemRead && Address == A_ST) ? 1'b0 : (m_ovr | m_chg);
      end else if (MemRead && Address == A_ST) begin
        m_chg <= 1'b0;
        m_ovr <= 1'b0;
      end
    end
  end

  function automatic logic is_mapped(input logic [31:0] a);
    return (a == A_PO) || (a == A_PI) || (a == A_ST);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a == A_PO) return m_portout;
    if (a == A_PI) return {24'b0, m_stable};
    if (a == A_ST) return {30'b0, m_ovr, m_chg};
    return 32'h0;
  endfunction

  // Monitor: checks PortOut every cycle and pops one expectation per load.
  always @(negedge clk) begin
    exp_t e;
    total++;
    if (PortOut !== m_portout) begin
      bad++;
      $display("FAIL portout: got %h want %h at %0t", PortOut, m_portout, $time);
    end
    if (MemRead) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: got a load at %h with no queued expectation at %0t", Address, $time);
      end else begin
        e = sb.pop_front();
        if (ReadData !== e.rd || IOSelect !== e.sel) begin
          bad++;
          $display("FAIL load_%h: got rd=%h sel=%b want rd=%h sel=%b at %0t",
                   e.addr, ReadData, IOSelect, e.rd, e.sel, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Address   = a;
    WriteData = d;
  endtask

  task automatic load(input logic [31:0] a);
    exp_t e;
    MemRead = 1'b1;
    Address = a;
    e.addr = a; e.rd = model_read(a); e.sel = is_mapped(a);
    sb.push_back(e);
  endtask

  task automatic load_c(input logic [31:0] a, input logic [31:0] v);
    exp_t e;
    MemRead = 1'b1;
    Address = a;
    e.addr = a; e.rd = v; e.sel = is_mapped(a);
    sb.push_back(e);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return A_PO;
      1:       return A_PI;
      2:       return A_ST;
      3:       return A_UN;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int hold;
    // Reset state, store/load, read-during-write, ignored stores
    tick(); reset = 1'b1; store(A_PO, 32'h1111_1111); load_c(A_ST, 32'h0);
    tick(); load_c(A_PO, 32'h0);
    tick(); store(A_PO, 32'hDEAD_BEEF); load_c(A_PO, 32'h0);
    tick(); load_c(A_PO, 32'hDEAD_BEEF);
    tick(); store(A_PO, 32'h0000_1234); load_c(A_PO, 32'hDEAD_BEEF);
    tick(); load_c(A_PO, 32'h0000_1234);
    tick(); store(A_PI, 32'hFFFF_FFFF);
    tick(); store(A_ST, 32'hFFFF_FFFF);
    tick(); store(A_UN, 32'hFFFF_FFFF); load_c(A_UN, 32'h0);
    tick(); load_c(A_PO, 32'h0000_1234);
    tick(); load_c(A_ST, 32'h0);

    // Glitches of 3 and D samples never qualify
    PortIn = 8'h3C; repeat (3) tick(); PortIn = 8'h00;
    repeat (8) tick(); load_c(A_PI, 32'h0);
    tick(); load_c(A_ST, 32'h0);
    PortIn = 8'h3C; repeat (D) tick(); PortIn = 8'h00;
    repeat (8) tick(); load_c(A_PI, 32'h0);
    tick(); load_c(A_ST, 32'h0);

    // Exact latency: still old one edge before k+1+D, new at k+1+D
    PortIn = 8'hA5; repeat (D + 1) tick(); load_c(A_PI, 32'h0);
    tick(); load_c(A_PI, 32'h0000_00A5);
    tick(); load_c(A_ST, 32'h1);
    tick(); load_c(A_ST, 32'h0);

    // Two changes without a read raise overrun
    PortIn = 8'h5A; repeat (7) tick();
    PortIn = 8'h11; repeat (7) tick(); load_c(A_ST, 32'h3);
    tick(); load_c(A_ST, 32'h0);
    tick(); load_c(A_PI, 32'h0000_0011);

    // Status read on the update edge: update wins, overrun stays clear
    PortIn = 8'h77; repeat (D + 1) tick(); load_c(A_ST, 32'h0);
    tick(); load_c(A_ST, 32'h1);
    tick(); load_c(A_PI, 32'h0000_0077);
    PortIn = 8'h88; repeat (7) tick();
    PortIn = 8'h99; repeat (D + 1) tick(); load_c(A_ST, 32'h1);
    tick(); load_c(A_ST, 32'h1);
    tick(); load_c(A_ST, 32'h0);

    // Reset mid-debounce overrides a store and forces full re-qualification
    PortIn = 8'hFF; repeat (2) tick();
    reset = 1'b1; store(A_PO, 32'h5555_5555); load_c(A_PO, 32'h0000_1234);
    tick(); load_c(A_PI, 32'h0);
    tick(); load_c(A_PO, 32'h0);
    repeat (D) tick(); load_c(A_PI, 32'h0);
    tick(); load_c(A_PI, 32'h0000_00FF);
    tick(); load_c(A_ST, 32'h1);

    // Randomized traffic against the reference model
    hold = 0;
    repeat (2000) begin
      tick();
      if (hold == 0) begin
        if ($urandom_range(0, 3) != 0) PortIn = 8'($urandom);
        hold = $urandom_range(1, D + 3);
      end
      hold--;
      if ($urandom_range(0, 99) < 2) reset = 1'b1;
      if ($urandom_range(0, 9) < 3) store(pick_addr(), $urandom);
      if ($urandom_range(0, 1) == 1) load(($urandom_range(0, 3) == 0) ? Address : pick_addr());
    end

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/io_port_controller.md
IO_PORT_CONTROLLER -- requirements
Module: io_port_controller

Interface
REQ-001 SHALL have parameter PORTOUT_ADDR, default 32'h1001_0024, meaning the address of the output port register (read/write).
REQ-002 SHALL have parameter PORTIN_ADDR, default 32'h1001_0028, meaning the address of the debounced input port (read-only).
REQ-003 SHALL have parameter STATUS_ADDR, default 32'h1001_002C, meaning the address of the status register (read, clear-on-read).
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 4, legal range 1..255, meaning the number of consecutive cycles a new input value must hold.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have port Address, input, 32 bits: processor data address.
REQ-008 SHALL have port WriteData, input, 32 bits: processor store data.
REQ-009 SHALL have port MemWrite, input, 1 bit: store strobe, sampled at the rising edge.
REQ-010 SHALL have port MemRead, input, 1 bit: load strobe.
REQ-011 SHALL have port PortIn, input, 8 bits: asynchronous external switches.
REQ-012 SHALL have port ReadData, output, 32 bits: combinational load data.
REQ-013 SHALL have port IOSelect, output, 1 bit: combinational; high when Address equals any of the three parameter addresses.
REQ-014 SHALL have port PortOut, output, 32 bits: registered output port.

Function
REQ-015 PortOut SHALL load WriteData at a rising edge when MemWrite=1 and Address=PORTOUT_ADDR, and SHALL hold its value otherwise.
REQ-016 Stores to PORTIN_ADDR, STATUS_ADDR, or any unmapped address SHALL have no effect.
REQ-017 ReadData SHALL be combinational and valid in the same cycle, independent of MemRead: {24'b0, Stable} at PORTIN_ADDR; PortOut at PORTOUT_ADDR; {30'b0, Overrun, Changed} at STATUS_ADDR; 0 at all other addresses.
REQ-018 PortIn SHALL pass through a two-flop synchronizer (Sync1, then Sync2) before any other use.
REQ-019 Debounce: a counter SHALL clear whenever Sync2 equals Stable or Sync2 differs from its previous-cycle value; otherwise it SHALL increment. When the counter reaches DEBOUNCE_CYCLES, Stable SHALL load Sync2 at that edge and the counter SHALL clear.
REQ-020 Latency: if edge k first captures a new PortIn value into Sync1 and the pin holds, Stable SHALL update at edge k+1+DEBOUNCE_CYCLES, exactly.
REQ-021 A glitch shorter than the debounce window SHALL never change Stable.
REQ-022 On each Stable update, Changed SHALL be set to 1; if Changed was already 1, Overrun SHALL also be set to 1.
REQ-023 A cycle with MemRead=1 and Address=STATUS_ADDR SHALL clear Changed and Overrun at that edge. If a Stable update occurs at the same edge, the update SHALL win: Changed=1 and Overrun=0.
REQ-024 When MemRead=1 and MemWrite=1 at PORTOUT_ADDR in the same cycle, ReadData SHALL return the old PortOut value and the write SHALL take effect at the edge.

Reset
REQ-025 While reset=1 at a rising edge: PortOut=0, Sync1=Sync2=0, Stable=0, counter=0, Changed=0, Overrun=0.
REQ-026 Reset SHALL override any simultaneous store or status clear.
REQ-027 Reset asserted mid-debounce SHALL abort the count; after reset releases, a held nonzero PortIn SHALL be re-qualified with the full latency.

Structure
REQ-028 Package mips_io_pkg SHALL hold the default address constants, the status bit indices (CHANGED_BIT=0, OVERRUN_BIT=1), and the data width 32.
REQ-029 Synchronizer plus debounce SHALL be a sub-module, input_debouncer, parameterised by width and DEBOUNCE_CYCLES, providing the Stable output and a one-cycle Update pulse.

Verification
REQ-030 Scenario 1: after reset, store 32'hDEADBEEF to 0x1001_0024 -> PortOut=32'hDEADBEEF after the edge; a load at 0x1001_0024 returns 32'hDEADBEEF.
REQ-031 Scenario 2: PortIn 0x00->0xA5 held, DEBOUNCE_CYCLES=4 -> a load at 0x1001_0028 returns 0x000000A5 starting at edge k+5, and a status load returns 0x1.
REQ-032 Scenario 3: PortIn pulses to 0x3C for 3 cycles, then returns to 0x00 -> Stable remains 0x00 and Changed remains 0.
REQ-033 Scenario 4: two qualified changes with no intervening status read -> status returns 0x3; the status read clears it, and the next status read returns 0x0.
REQ-034 Scenario 5: status read on the same edge as a Stable update -> status afterwards equals 0x1.
REQ-035 Scenario 6: reset pulsed two cycles into debouncing 0xFF, with PortOut=0x1234 -> PortOut=0 and Stable=0; Stable reaches 0xFF exactly 1+DEBOUNCE_CYCLES edges after the first post-reset Sync1 capture.
